// File: rtl/fir_req_pkg.sv
// fir_req_pkg: shared constants and helpers for the FIR output requantizer.
// Saturation bounds, rounding constant and FIFO address width helpers.
package fir_req_pkg;

  localparam int CNT_W = 16;

  function automatic logic signed [63:0] sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  // Half-LSB of the post-shift result, so the shift rounds half-up.
  function automatic logic signed [63:0] round_const(input int shift);
    if (shift == 0) return 64'sd0;
    return 64'sd1 <<< (shift - 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fir_req_fifo.sv
// fir_req_fifo: synchronous first-word-fall-through FIFO, pointer+count.
// Ports: push_i/data_i write, pop_i read, data_o head, full_o, empty_o.
module fir_req_fifo
  import fir_req_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is taken only when a pop frees a slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: round/shift/saturate/decimate FIR results into a FIFO.
// Ports: i_data/i_data_rdy in; o_data/o_valid/i_ready out stream; o_sat,
// o_drop pulses, o_err_sticky. FIR_REQ_STATS_EN adds o_sat_cnt/o_drop_cnt.
module fir_out_requant
  import fir_req_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_data_rdy,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sat,
  output logic             o_drop,
  output logic             o_err_sticky
`ifdef FIR_REQ_STATS_EN
  ,
  output logic [CNT_W-1:0] o_sat_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
`endif
);

  localparam logic signed [63:0] RND64 = round_const(SHIFT);
  localparam logic signed [63:0] MAX64 = sat_max(OUT_W);
  localparam logic signed [63:0] MIN64 = sat_min(OUT_W);
  localparam logic signed [IN_W:0] RND  = RND64[IN_W:0];
  localparam logic signed [IN_W:0] MAXV = MAX64[IN_W:0];
  localparam logic signed [IN_W:0] MINV = MIN64[IN_W:0];
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCW-1:0] DC_LAST = DCW'(DECIM - 1);

  // S1: one extra bit keeps the rounding add from wrapping.
  logic signed [IN_W:0] sum, r1_d, r1_q;
  logic                 s1_vld_q;

  assign sum  = $signed({i_data[IN_W-1], i_data}) + RND;
  assign r1_d = sum >>> SHIFT;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_vld_q <= 1'b0;
      r1_q     <= '0;
    end else begin
      s1_vld_q <= i_data_rdy;
      if (i_data_rdy) r1_q <= r1_d;
    end
  end

  // S2: clip and decimate.
  logic [OUT_W-1:0] s2_data_d, s2_data_q;
  logic             s2_sat_d, s2_sat_q, s2_vld_q;
  logic [DCW-1:0]   dcnt_d, dcnt_q;
  logic             keep;

  always_comb begin
    s2_data_d = r1_q[OUT_W-1:0];
    s2_sat_d  = 1'b0;
    if (r1_q > MAXV) begin
      s2_data_d = MAXV[OUT_W-1:0];
      s2_sat_d  = 1'b1;
    end else if (r1_q < MINV) begin
      s2_data_d = MINV[OUT_W-1:0];
      s2_sat_d  = 1'b1;
    end
  end

  assign keep = s1_vld_q & (dcnt_q == '0);

  always_comb begin
    dcnt_d = dcnt_q;
    if (s1_vld_q) begin
      dcnt_d = (dcnt_q == DC_LAST) ? '0 : dcnt_q + DCW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_vld_q  <= 1'b0;
      s2_sat_q  <= 1'b0;
      s2_data_q <= '0;
      dcnt_q    <= '0;
    end else begin
      s2_vld_q <= keep;
      dcnt_q   <= dcnt_d;
      if (keep) begin
        s2_sat_q  <= s2_sat_d;
        s2_data_q <= s2_data_d;
      end
    end
  end

  // Output buffer.
  logic [OUT_W-1:0] head;
  logic             full, empty, pop, accept;
  logic             err_q;

  fir_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (s2_vld_q),
    .data_i  (s2_data_q),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign o_valid = ~empty;
  assign o_data  = o_valid ? head : '0;
  assign pop     = o_valid & i_ready;
  assign accept  = s2_vld_q & (~full | pop);
  // A dropped sample reports only the drop, never the clip.
  assign o_sat   = accept & s2_sat_q;
  assign o_drop  = s2_vld_q & full & ~pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) err_q <= 1'b0;
    else         err_q <= err_q | o_sat | o_drop;
  end

  assign o_err_sticky = err_q;

`ifdef FIR_REQ_STATS_EN
  logic [CNT_W-1:0] sat_cnt_q, drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (o_sat && (sat_cnt_q != '1))
        sat_cnt_q <= sat_cnt_q + CNT_W'(1);
      if (o_drop && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign o_sat_cnt  = sat_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed bench for fir_out_requant.
// DUT a uses defaults; DUT b uses DECIM=3.
module tb_fir_out_requant;

  logic        clk;
  logic        a_rst, a_rdy, a_ready;
  logic [31:0] a_in;
  logic [15:0] a_odata;
  logic        a_valid, a_sat, a_drop, a_err;
  logic        b_rst, b_rdy, b_ready;
  logic [31:0] b_in;
  logic [15:0] b_odata;
  logic        b_valid, b_sat, b_drop, b_err;
`ifdef FIR_REQ_STATS_EN
  logic [15:0] a_scnt, a_dcnt, b_scnt, b_dcnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int a_sat_n = 0, a_drop_n = 0, b_sat_n = 0, b_drop_n = 0;
  int a_got[$];
  int b_got[$];

  fir_out_requant u_a (
    .i_clk        (clk),
    .i_reset      (a_rst),
    .i_data       (a_in),
    .i_data_rdy   (a_rdy),
    .o_data       (a_odata),
    .o_valid      (a_valid),
    .i_ready      (a_ready),
    .o_sat        (a_sat),
    .o_drop       (a_drop),
    .o_err_sticky (a_err)
`ifdef FIR_REQ_STATS_EN
    ,
    .o_sat_cnt    (a_scnt),
    .o_drop_cnt   (a_dcnt)
`endif
  );

  fir_out_requant #(.DECIM(3)) u_b (
    .i_clk        (clk),
    .i_reset      (b_rst),
    .i_data       (b_in),
    .i_data_rdy   (b_rdy),
    .o_data       (b_odata),
    .o_valid      (b_valid),
    .i_ready      (b_ready),
    .o_sat        (b_sat),
    .o_drop       (b_drop),
    .o_err_sticky (b_err)
`ifdef FIR_REQ_STATS_EN
    ,
    .o_sat_cnt    (b_scnt),
    .o_drop_cnt   (b_dcnt)
`endif
  );

  always #5 clk = ~clk;

  // Outputs are sampled mid-cycle; inputs change 1 after the rising edge.
  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_sat) a_sat_n++;
      if (a_drop) a_drop_n++;
      if (a_valid && a_ready) a_got.push_back(int'($signed(a_odata)));
    end
    if (!b_rst) begin
      if (b_sat) b_sat_n++;
      if (b_drop) b_drop_n++;
      if (b_valid && b_ready) b_got.push_back(int'($signed(b_odata)));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a;
    a_rst = 1'b1; a_rdy = 1'b0; a_ready = 1'b0;
    tick(); tick();
    a_rst = 1'b0;
    a_got.delete();
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    n_chk++;
    if (a_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", a_valid);
    else n_pass++;
    n_chk++;
    if (a_odata !== 16'h0) $display("FAIL rst_data got %h exp 0000", a_odata);
    else n_pass++;
    n_chk++;
    if ({a_sat, a_drop, a_err} !== 3'b000)
      $display("FAIL rst_flags got %b exp 000", {a_sat, a_drop, a_err});
    else n_pass++;
    n_chk++;
    if (b_valid !== 1'b0) $display("FAIL rst_b_valid got %b exp 0", b_valid);
    else n_pass++;
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    n_chk++;
    if (a_valid !== 1'b0) $display("FAIL rst_idle got %b exp 0", a_valid);
    else n_pass++;
  endtask

  task automatic test_rounding;
    logic [31:0] vin [4];
    logic [15:0] vexp [4];
    int          vsat [4];
    int          s0;
    vin  = '{32'h0000_1280, 32'hFFFF_FE80, 32'h7FFF_FFFF, 32'h8000_0000};
    vexp = '{16'h0013, 16'hFFFF, 16'h7FFF, 16'h8000};
    vsat = '{0, 0, 1, 1};
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = a_sat_n;
      a_in = vin[i]; a_rdy = 1'b1;
      tick();
      a_rdy = 1'b0;
      n_chk++;
      if (a_valid !== 1'b0) $display("FAIL lat1[%0d] got %b exp 0", i, a_valid);
      else n_pass++;
      tick();
      n_chk++;
      if (a_valid !== 1'b0) $display("FAIL lat2[%0d] got %b exp 0", i, a_valid);
      else n_pass++;
      tick();
      n_chk++;
      if (a_valid !== 1'b1) $display("FAIL lat3[%0d] got %b exp 1", i, a_valid);
      else n_pass++;
      n_chk++;
      if (a_odata !== vexp[i])
        $display("FAIL round[%0d] got %h exp %h", i, a_odata, vexp[i]);
      else n_pass++;
      tick();
      n_chk++;
      if (a_valid !== 1'b0) $display("FAIL pop[%0d] got %b exp 0", i, a_valid);
      else n_pass++;
      n_chk++;
      if (a_sat_n - s0 !== vsat[i])
        $display("FAIL sat[%0d] got %0d exp %0d", i, a_sat_n - s0, vsat[i]);
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (a_err !== 1'b0) $display("FAIL sticky_pre got %b exp 0", a_err);
        else n_pass++;
      end
    end
    tick(); tick();
    n_chk++;
    if (a_err !== 1'b1) $display("FAIL sticky_hold got %b exp 1", a_err);
    else n_pass++;
    a_ready = 1'b0;
  endtask

  task automatic test_overflow;
    int d0, s0;
    reset_a();
    n_chk++;
    if (a_err !== 1'b0) $display("FAIL sticky_clr got %b exp 0", a_err);
    else n_pass++;
    d0 = a_drop_n; s0 = a_sat_n;
    for (int k = 1; k <= 6; k++) begin
      a_in = 32'(k * 256); a_rdy = 1'b1;
      tick();
    end
    a_rdy = 1'b0;
    tick(); tick(); tick();
    n_chk++;
    if (a_drop_n - d0 !== 2) $display("FAIL ovf_drops got %0d exp 2", a_drop_n - d0);
    else n_pass++;
    n_chk++;
    if (a_sat_n - s0 !== 0) $display("FAIL ovf_sat got %0d exp 0", a_sat_n - s0);
    else n_pass++;
    n_chk++;
    if (a_err !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", a_err);
    else n_pass++;
    n_chk++;
    if (a_odata !== 16'h0001) $display("FAIL ovf_head got %h exp 0001", a_odata);
    else n_pass++;
    a_got.delete();
    a_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    a_ready = 1'b0;
    n_chk++;
    if (a_got.size() !== 4) $display("FAIL ovf_count got %0d exp 4", a_got.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < a_got.size(); k++) begin
      n_chk++;
      if (a_got[k] !== k + 1) $display("FAIL ovf_rd[%0d] got %0d exp %0d", k, a_got[k], k + 1);
      else n_pass++;
    end
    n_chk++;
    if (a_valid !== 1'b0) $display("FAIL ovf_empty got %b exp 0", a_valid);
    else n_pass++;
  endtask

  task automatic test_full_pop;
    int d0;
    reset_a();
    for (int k = 7; k <= 10; k++) begin
      a_in = 32'(k * 256); a_rdy = 1'b1;
      tick();
    end
    a_rdy = 1'b0;
    tick(); tick(); tick();
    d0 = a_drop_n;
    a_in = 32'h0000_0B00; a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
    tick();
    n_chk++;
    if (a_odata !== 16'd7) $display("FAIL fp_head got %0d exp 7", a_odata);
    else n_pass++;
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    n_chk++;
    if (a_drop_n - d0 !== 0) $display("FAIL fp_drop got %0d exp 0", a_drop_n - d0);
    else n_pass++;
    n_chk++;
    if (a_odata !== 16'd8) $display("FAIL fp_next got %0d exp 8", a_odata);
    else n_pass++;
    a_got.delete();
    a_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    a_ready = 1'b0;
    n_chk++;
    if (a_got.size() !== 4) $display("FAIL fp_count got %0d exp 4", a_got.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < a_got.size(); k++) begin
      n_chk++;
      if (a_got[k] !== k + 8) $display("FAIL fp_rd[%0d] got %0d exp %0d", k, a_got[k], k + 8);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    reset_a();
    d0 = a_drop_n;
    a_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a_in = 32'(k * 256); a_rdy = 1'b1;
      tick();
    end
    a_rdy = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    a_ready = 1'b0;
    n_chk++;
    if (a_got.size() !== 5) $display("FAIL b2b_count got %0d exp 5", a_got.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < a_got.size(); k++) begin
      n_chk++;
      if (a_got[k] !== k + 1) $display("FAIL b2b_rd[%0d] got %0d exp %0d", k, a_got[k], k + 1);
      else n_pass++;
    end
    n_chk++;
    if (a_drop_n - d0 !== 0) $display("FAIL b2b_drop got %0d exp 0", a_drop_n - d0);
    else n_pass++;
  endtask

  task automatic test_decim;
    b_got.delete();
    b_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      b_in = 32'(k * 256); b_rdy = 1'b1;
      tick();
    end
    b_rdy = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    n_chk++;
    if (b_got.size() !== 2) $display("FAIL dec_count got %0d exp 2", b_got.size());
    else n_pass++;
    n_chk++;
    if (b_got.size() != 2 || b_got[0] !== 1 || b_got[1] !== 4)
      $display("FAIL dec_vals got %p exp '{1,4}", b_got);
    else n_pass++;
    b_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      b_in = 32'(k * 256); b_rdy = 1'b1;
      tick();
    end
    n_chk++;
    if (b_valid !== 1'b1) $display("FAIL dec_pre got %b exp 1", b_valid);
    else n_pass++;
    b_rdy = 1'b0; b_rst = 1'b1;
    tick();
    n_chk++;
    if (b_valid !== 1'b0) $display("FAIL dec_rst got %b exp 0", b_valid);
    else n_pass++;
    b_rst = 1'b0;
    b_got.delete();
    b_ready = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      b_in = 32'(k * 256); b_rdy = 1'b1;
      tick();
    end
    b_rdy = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    b_ready = 1'b0;
    n_chk++;
    if (b_got.size() != 2 || b_got[0] !== 7 || b_got[1] !== 10)
      $display("FAIL dec_restart got %p exp '{7,10}", b_got);
    else n_pass++;
    n_chk++;
    if (b_sat_n + b_drop_n !== 0)
      $display("FAIL dec_flags got %0d exp 0", b_sat_n + b_drop_n);
    else n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    a_rst = 1'b1; a_rdy = 1'b0; a_ready = 1'b0; a_in = '0;
    b_rst = 1'b1; b_rdy = 1'b0; b_ready = 1'b0; b_in = '0;
    test_reset();
    test_rounding();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_decim();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
